prediction_argmax: RTL and testbench
====================================

Name: prediction_argmax

Overview:
- Final stage of the digit-classifier datapath; feeds the 7-segment display driver directly.
- Consumes the 10 class scores of one inference, streamed serially in class order 0..9.
- Computes the signed argmax and holds the winning class as a 4-bit prediction until the next complete frame.
- Codes >9 (reset value, error code) render blank downstream.

Parameters:
- SCORE_W, 16, width of each signed two's-complement class score
- NUM_CLASSES, 10, scores per frame; legal range 2..10 so the index fits in 4 bits

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- score_valid  input  1  score_data/score_last are valid this cycle
- score_ready  output  1  block can accept a score this cycle
- score_data  input  SCORE_W  signed score of the current class
- score_last  input  1  marks the final score of a frame
- pred_num  output  4  held prediction, 0..NUM_CLASSES-1; 4'hF after reset; 4'hE after framing error
- pred_valid  output  1  one-cycle pulse when pred_num updates
- frame_err  output  1  one-cycle pulse on framing error
- busy  output  1  a frame is partially received (index != 0)

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset values: pred_num=4'hF, pred_valid=0, frame_err=0, busy=0, score_ready=1, state=ACCUM, idx=0, max_val=0, max_idx=0.
- Transfer occurs when score_valid && score_ready at a rising edge. No transfer means no state change.
- States:
  - ACCUM: score_ready=1. Each transfer increments idx.
    - idx==0: max_val<=score_data, max_idx<=0. The running max is seeded by the first score, never by zero.
    - idx>0: update max_val/max_idx only if score_data > max_val (signed, strict). Ties keep the lower index.
    - Transfer at idx==NUM_CLASSES-1 with score_last=1: go to DONE, idx<=0.
    - Framing error: score_last=1 at idx<NUM_CLASSES-1, or score_last=0 at idx==NUM_CLASSES-1. Go to ERR, idx<=0; the frame is discarded.
  - DONE: one cycle. score_ready=0. pred_num<=winning index (including the last score's compare). pred_valid=1. Return to ACCUM.
  - ERR: one cycle. score_ready=0. pred_num<=4'hE. frame_err=1. Return to ACCUM.
- Latency: final score transferred at edge N; pred_num valid and pred_valid high in the cycle after edge N, with score_ready low for that cycle. Next frame can begin at edge N+2.
- pred_num changes only on DONE/ERR entry or reset; it is stable otherwise, including mid-frame.
- busy = (idx != 0) in ACCUM.
- Reset mid-frame discards the partial frame and restores all reset values. rst has priority over a simultaneous transfer.
- score_data is sampled only on transfer. Values while score_valid=0 are ignored, including X.
- Arithmetic: compare at full SCORE_W signed. No saturation or truncation. max_idx is 4 bits.

Test Plan:
- Reset then idle 5 cycles -> pred_num=4'hF, pred_valid=0, score_ready=1, busy=0.
- Frame scores 0,10,20,...,90 with last on class 9 -> one cycle after the final transfer, pred_num=9 and pred_valid=1 for exactly 1 cycle; score_ready=0 that cycle.
- All-negative frame {-5,-3,-100,-3,-7,-8,-9,-10,-11,-12} -> pred_num=1 (tie with class 3 resolves low); also all-equal frame of 7s -> pred_num=0.
- score_valid toggling 1/0 every cycle across a frame whose max is class 6 (score 32767), with X on score_data when invalid -> pred_num=6 after the 10th transfer, busy high from the first to the 10th transfer.
- score_last on class 4, then on class 9 without the earlier flag in a new frame -> first: frame_err pulse, pred_num=4'hE; second frame (correct framing, max class 2) -> pred_num=2.
- rst asserted after 6 transfers, then a full frame with max at class 0 -> pred_num=4'hF after reset, then 0 with a pred_valid pulse; no spurious pred_valid from the aborted frame.

Source files
------------

// File: rtl/prediction_argmax.sv
// prediction_argmax: signed argmax over one frame of NUM_CLASSES serial class scores.
// Latency: prediction and pred_valid appear the cycle after the final score transfer.
// Backpressure: score_ready drops for that one cycle (DONE/ERR); otherwise always ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   score_valid/score_ready  handshake for score_data/score_last (class order 0..N-1)
//   pred_num                 held winner, 4'hF after reset, 4'hE after framing error
//   pred_valid, frame_err    one-cycle pulses on DONE / ERR
//   busy                     a frame is partially received
module prediction_argmax #(
  parameter int SCORE_W     = 16,
  parameter int NUM_CLASSES = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      score_valid,
  output logic                      score_ready,
  input  logic signed [SCORE_W-1:0] score_data,
  input  logic                      score_last,
  output logic [3:0]                pred_num,
  output logic                      pred_valid,
  output logic                      frame_err,
  output logic                      busy
);

  typedef enum logic [1:0] {ACCUM, DONE, ERR} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);
  localparam logic [3:0] PRED_RST = 4'hF;
  localparam logic [3:0] PRED_ERR = 4'hE;

  state_t                    state_q;
  logic [3:0]                idx_q;
  logic signed [SCORE_W-1:0] max_val_q;
  logic [3:0]                max_idx_q;
  logic [3:0]                pred_num_q;
  logic                      pred_valid_q;
  logic                      frame_err_q;
  logic                      busy_q;
  logic                      score_ready_q;

  logic                      xfer;
  logic                      take;
  logic                      at_end;
  logic                      framing_bad;
  logic signed [SCORE_W-1:0] max_val_d;
  logic [3:0]                max_idx_d;

  assign xfer = score_valid && score_ready_q;

  // The first score of a frame always seeds the running max; afterwards only a
  // strictly larger score wins, so ties keep the lower class index.
  always_comb begin
    take        = 1'b0;
    at_end      = 1'b0;
    framing_bad = 1'b0;
    max_val_d   = max_val_q;
    max_idx_d   = max_idx_q;
    take        = (idx_q == 4'd0) || (score_data > max_val_q);
    at_end      = (idx_q == LAST_IDX);
    framing_bad = (score_last != at_end);
    if (take) begin
      max_val_d = score_data;
      max_idx_d = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ACCUM;
      idx_q         <= 4'd0;
      max_val_q     <= '0;
      max_idx_q     <= 4'd0;
      pred_num_q    <= PRED_RST;
      pred_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
      score_ready_q <= 1'b1;
    end else begin
      pred_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        ACCUM: begin
          if (xfer) begin
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
            if (framing_bad) begin
              state_q       <= ERR;
              idx_q         <= 4'd0;
              busy_q        <= 1'b0;
              score_ready_q <= 1'b0;
              pred_num_q    <= PRED_ERR;
              frame_err_q   <= 1'b1;
            end else if (at_end) begin
              // Winner includes the compare against this final score.
              state_q       <= DONE;
              idx_q         <= 4'd0;
              busy_q        <= 1'b0;
              score_ready_q <= 1'b0;
              pred_num_q    <= max_idx_d;
              pred_valid_q  <= 1'b1;
            end else begin
              idx_q  <= idx_q + 4'd1;
              busy_q <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          state_q       <= ACCUM;
          score_ready_q <= 1'b1;
        end
        default: begin
          state_q       <= ACCUM;
          score_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign score_ready = score_ready_q;
  assign pred_num    = pred_num_q;
  assign pred_valid  = pred_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_prediction_argmax.sv
// Directed bench for prediction_argmax: reset state, argmax over several score
// patterns, tie resolution, gapped input with X data, framing errors, mid-frame reset.
module tb_prediction_argmax;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               score_valid = 1'b0;
  logic               score_ready;
  logic signed [15:0] score_data = 'x;
  logic               score_last = 1'b0;
  logic [3:0]         pred_num;
  logic               pred_valid;
  logic               frame_err;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int pv_cnt = 0;
  logic signed [15:0] sc [10];

  prediction_argmax #(.SCORE_W(16), .NUM_CLASSES(10)) dut (
    .clk(clk), .rst(rst),
    .score_valid(score_valid), .score_ready(score_ready),
    .score_data(score_data), .score_last(score_last),
    .pred_num(pred_num), .pred_valid(pred_valid),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pred_valid === 1'b1) pv_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer; returns #1 after the edge that took it.
  task automatic send(input logic signed [15:0] d, input logic last);
    int t = 0;
    score_valid = 1'b1;
    score_data  = d;
    score_last  = last;
    while (score_ready !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    if (t == 20) check("ready_timeout", 32'(score_ready), 32'd1);
    tick();
    score_valid = 1'b0;
    score_data  = 'x;
    score_last  = 1'b0;
  endtask

  // Back-to-back frame from sc[]; last flag placed at index last_pos.
  task automatic send_frame(input int last_pos);
    for (int i = 0; i < 10; i++) send(sc[i], (i == last_pos));
  endtask

  initial begin
    // Reset, then idle
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("rst_pred", 32'(pred_num), 32'hF);
    check("rst_pv", 32'(pred_valid), 32'd0);
    check("rst_rdy", 32'(score_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);

    // Ascending ramp: winner is the last class
    for (int i = 0; i < 10; i++) sc[i] = 16'(i * 10);
    send_frame(9);
    check("ramp_pred", 32'(pred_num), 32'd9);
    check("ramp_pv", 32'(pred_valid), 32'd1);
    check("ramp_rdy", 32'(score_ready), 32'd0);
    tick();
    check("ramp_pv_pulse", 32'(pred_valid), 32'd0);
    check("ramp_rdy_back", 32'(score_ready), 32'd1);
    check("ramp_hold", 32'(pred_num), 32'd9);

    // All negative with tie between classes 1 and 3
    sc = '{-16'sd5, -16'sd3, -16'sd100, -16'sd3, -16'sd7,
           -16'sd8, -16'sd9, -16'sd10, -16'sd11, -16'sd12};
    send_frame(9);
    check("neg_pred", 32'(pred_num), 32'd1);
    tick();

    // All equal
    for (int i = 0; i < 10; i++) sc[i] = 16'sd7;
    send_frame(9);
    check("eq_pred", 32'(pred_num), 32'd0);
    tick();

    // Gapped input with X on idle cycles, max 32767 at class 6
    sc = '{16'sd100, -16'sd200, 16'sd300, 16'sd5, -16'sd32768,
           16'sd0, 16'sd32767, 16'sd32766, 16'sd1, 16'sd2};
    for (int i = 0; i < 10; i++) begin
      send(sc[i], (i == 9));
      if (i < 9) begin
        check($sformatf("gap_busy%0d", i), 32'(busy), 32'd1);
        if (i == 4) check("gap_pred_stable", 32'(pred_num), 32'd0);
      end else begin
        check("gap_pred", 32'(pred_num), 32'd6);
        check("gap_pv", 32'(pred_valid), 32'd1);
        check("gap_busy_end", 32'(busy), 32'd0);
      end
      tick();  // idle cycle with score_valid=0, score_data=X
    end

    // Early last on class 4
    for (int i = 0; i < 5; i++) send(16'(i), (i == 4));
    check("early_ferr", 32'(frame_err), 32'd1);
    check("early_pred", 32'(pred_num), 32'hE);
    check("early_pv", 32'(pred_valid), 32'd0);
    check("early_rdy", 32'(score_ready), 32'd0);
    tick();
    check("early_ferr_pulse", 32'(frame_err), 32'd0);
    check("early_hold", 32'(pred_num), 32'hE);

    // Missing last on class 9
    for (int i = 0; i < 10; i++) sc[i] = 16'(i);
    send_frame(15);
    check("nolast_ferr", 32'(frame_err), 32'd1);
    check("nolast_pred", 32'(pred_num), 32'hE);
    tick();

    // Correct framing after errors, max at class 2
    sc = '{16'sd1, 16'sd2, 16'sd50, 16'sd3, 16'sd4,
           16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd9};
    send_frame(9);
    check("ok_pred", 32'(pred_num), 32'd2);
    check("ok_ferr", 32'(frame_err), 32'd0);
    tick();

    // Mid-frame reset after 6 transfers
    for (int i = 0; i < 6; i++) send(16'sd20000, 1'b0);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_pred", 32'(pred_num), 32'hF);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pv", 32'(pred_valid), 32'd0);
    repeat (3) tick();
    sc = '{16'sd1000, -16'sd1, 16'sd999, 16'sd0, 16'sd5,
           16'sd6, 16'sd7, 16'sd8, 16'sd9, 16'sd1000};
    send_frame(9);
    check("post_rst_pred", 32'(pred_num), 32'd0);
    check("post_rst_pv", 32'(pred_valid), 32'd1);
    repeat (2) tick();

    // Six good frames completed in total
    check("pv_count", 32'(pv_cnt), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
